// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI frame geometry, register map and controller state encoding
package spi_pkg;
    localparam int SPI_FRAME_W = 16;
    localparam int SPI_ADDR_W  = 7;
    localparam int SPI_DATA_W  = 8;
    localparam int SPI_RW_BIT  = 15;

    localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [SPI_ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} spi_state_e;

    function automatic logic [SPI_FRAME_W-1:0] spi_frame(
        input logic                  rw,
        input logic [SPI_ADDR_W-1:0] addr,
        input logic [SPI_DATA_W-1:0] data
    );
        return {rw, addr, data};
    endfunction
endpackage

// File: rtl/spi_controller_if.sv
// spi_controller_if: command handshake and completion bus of the SPI controller
interface spi_controller_if;
    import spi_pkg::*;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_rw;
    logic [SPI_ADDR_W-1:0] cmd_addr;
    logic [SPI_DATA_W-1:0] cmd_wdata;
    logic                  done;
    logic [SPI_DATA_W-1:0] rd_data;
    logic                  busy;

    modport master (output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
                    input  cmd_ready, done, rd_data, busy);
    modport slave  (input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
                    output cmd_ready, done, rd_data, busy);
endinterface

// File: rtl/spi_clk_div.sv
// spi_clk_div: SCLK half-period counter producing rise/fall strobes while enabled
module spi_clk_div #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_rise_o,
    output logic tick_fall_o
);
    logic [7:0] cnt_q, cnt_d;
    logic       ph_q, ph_d;
    logic       wrap;

    assign wrap        = cnt_q == 8'(CLK_DIV - 1);
    assign tick_rise_o = en_i && wrap && !ph_q;
    assign tick_fall_o = en_i && wrap && ph_q;

    // Count one half-period; phase flips at each wrap, everything clears when disabled
    always_comb begin
        cnt_d = (!en_i || wrap) ? 8'd0 : cnt_q + 8'd1;
        ph_d  = en_i && (ph_q ^ wrap);
    end

    // Counter and phase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
        end
    end
endmodule

// File: rtl/spi_controller.sv
// spi_controller: serialises one 16-bit command per handshake as an SPI mode-0 frame
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = 5,
    parameter int GAP_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_controller_if.slave  cmd,
    input  logic             cipo_i,
    output logic             ncs_o,
    output logic             sclk_o,
    output logic             copi_o
);
    localparam int GW = $clog2(GAP_CYCLES);

    if (CLK_DIV < 3 || CLK_DIV > 255) begin : g_bad_div
        $error("spi_controller: CLK_DIV must be in 3..255");
    end
    if (GAP_CYCLES < 2) begin : g_bad_gap
        $error("spi_controller: GAP_CYCLES must be at least 2");
    end

    spi_state_e             state_q, state_d;
    logic [SPI_FRAME_W-1:0] sr_q, sr_d;
    logic [3:0]             bit_q, bit_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic                   rw_q, rw_d;
    logic [SPI_DATA_W-1:0]  rd_sh_q, rd_sh_d;
    logic [SPI_DATA_W-1:0]  rd_q, rd_d;
    logic                   ncs_q, ncs_d;
    logic                   sclk_q, sclk_d;
    logic                   done_q, done_d;
    logic                   ready_q, ready_d;
    logic                   cipo_m_q, cipo_s_q;
    logic                   div_en, tick_rise, tick_fall;

    assign div_en = state_q inside {S_SETUP, S_SHIFT, S_HOLD};

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (div_en),
        .tick_rise_o(tick_rise),
        .tick_fall_o(tick_fall)
    );

    assign ncs_o         = ncs_q;
    assign sclk_o        = sclk_q;
    assign copi_o        = sr_q[SPI_RW_BIT];
    assign cmd.cmd_ready = ready_q;
    assign cmd.busy      = !ready_q;
    assign cmd.done      = done_q;
    assign cmd.rd_data   = rd_q;

    // Next state: SETUP is the low half of bit 15, SHIFT runs until the fall after the 16th rise
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        rw_d    = rw_q;
        rd_sh_d = rd_sh_q;
        rd_d    = rd_q;
        ncs_d   = ncs_q;
        sclk_d  = sclk_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid && ready_q) begin
                    state_d = S_SETUP;
                    sr_d    = spi_frame(cmd.cmd_rw, cmd.cmd_addr, cmd.cmd_wdata);
                    rw_d    = cmd.cmd_rw;
                    bit_d   = '0;
                    ncs_d   = 1'b0;
                    sclk_d  = 1'b0;
                end
            end
            S_SETUP, S_SHIFT: begin
                if (tick_rise) begin
                    state_d = S_SHIFT;
                    sclk_d  = 1'b1;
                    if (!rw_q && bit_q[3]) rd_sh_d = {rd_sh_q[SPI_DATA_W-2:0], cipo_s_q};
                end else if (tick_fall) begin
                    sclk_d = 1'b0;
                    if (bit_q == 4'd15) begin
                        state_d = S_HOLD;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        sr_d  = sr_q << 1;
                    end
                end
            end
            S_HOLD: begin
                if (tick_rise) begin
                    state_d = S_GAP;
                    ncs_d   = 1'b1;
                    done_d  = 1'b1;
                    gap_d   = '0;
                    sr_d    = '0;
                    if (!rw_q) rd_d = rd_sh_q;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_IDLE;
                else gap_d = gap_q + GW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = state_d == S_IDLE;
    end

    // State, datapath and output registers; CIPO passes a 2-flop synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sr_q     <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            rw_q     <= 1'b0;
            rd_sh_q  <= '0;
            rd_q     <= '0;
            ncs_q    <= 1'b1;
            sclk_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            cipo_m_q <= 1'b0;
            cipo_s_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            rw_q     <= rw_d;
            rd_sh_q  <= rd_sh_d;
            rd_q     <= rd_d;
            ncs_q    <= ncs_d;
            sclk_q   <= sclk_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            cipo_m_q <= cipo_i;
            cipo_s_q <= cipo_m_q;
        end
    end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: scoreboard bench for the SPI controller (CLK_DIV=5 and CLK_DIV=3 instances)
module tb_spi_controller;
    import spi_pkg::*;
    localparam int D  = 5;
    localparam int G  = 10;
    localparam int D3 = 3;

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rd;
        int          t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cipo, ncs, sclk, copi;
    logic cipo3 = 1'b0;
    logic ncs3, sclk3, copi3;
    logic [15:0] resp = '0;
    logic [7:0]  exp_rd = '0;

    int tests = 0, fails = 0, cyc = 0;
    int rises = 0, first_rise = 0, ncs_fall = 0, bad_edges = 0, done_seen = 0;
    int rises3 = 0, last_t0 = 0;
    logic [15:0] frame_cap = '0, frame3 = '0, last_frame = '0;
    logic ncs_p = 1'b1, sclk_p = 1'b0, rdy_p = 1'b1, ncs3_p = 1'b1, sclk3_p = 1'b0;
    logic t0_ok = 1'b0;
    exp_t sb[$];
    exp_t e;
    int hs_q[$];

    spi_controller_if cif();
    spi_controller_if cif3();

    spi_controller #(.CLK_DIV(D), .GAP_CYCLES(G)) u5 (
        .clk(clk), .rst_n(rst_n), .cmd(cif), .cipo_i(cipo),
        .ncs_o(ncs), .sclk_o(sclk), .copi_o(copi)
    );
    spi_controller #(.CLK_DIV(D3), .GAP_CYCLES(G)) u3 (
        .clk(clk), .rst_n(rst_n), .cmd(cif3), .cipo_i(cipo3),
        .ncs_o(ncs3), .sclk_o(sclk3), .copi_o(copi3)
    );

    always #5 clk = ~clk;

    // CIPO model: presents response bit (15 - rises) right after each rise
    assign cipo = (rises < 16) ? resp[4'(15 - rises)] : 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: frame capture, handshake-driven scoreboard push, pop and compare on done
    initial forever begin
        @(negedge clk);
        if (!ncs && ncs_p) begin
            rises = 0;
            ncs_fall = cyc;
        end
        if (sclk && !sclk_p) begin
            if (ncs) bad_edges++;
            else begin
                if (rises == 0) first_rise = cyc;
                frame_cap = {frame_cap[14:0], copi};
                rises++;
            end
        end
        if (!ncs3 && ncs3_p) rises3 = 0;
        if (sclk3 && !sclk3_p && !ncs3) begin
            frame3 = {frame3[14:0], copi3};
            rises3++;
        end
        if (cif.cmd_ready && !rdy_p && t0_ok) begin
            chk("ready_return", cyc, last_t0 + 1 + 33 * D + G);
            t0_ok = 1'b0;
        end
        if (cif.cmd_valid && cif.cmd_ready) begin
            if (!cif.cmd_rw) exp_rd = resp[7:0];
            sb.push_back('{frame: {cif.cmd_rw, cif.cmd_addr, cif.cmd_wdata}, rd: exp_rd, t0: cyc});
            hs_q.push_back(cyc);
            last_t0 = cyc;
            t0_ok = 1'b1;
        end
        if (cif.done) begin
            done_seen++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                last_frame = frame_cap;
                chk("frame", frame_cap, e.frame);
                chk("rise_count", rises, 16);
                chk("ncs_fall_cyc", ncs_fall, e.t0 + 1);
                chk("first_rise_cyc", first_rise, e.t0 + 1 + D);
                chk("done_cyc", cyc, e.t0 + 1 + 33 * D);
                chk("rd_data", cif.rd_data, e.rd);
                chk("ncs_at_done", ncs, 1);
            end
        end
        ncs_p = ncs; sclk_p = sclk; rdy_p = cif.cmd_ready;
        ncs3_p = ncs3; sclk3_p = sclk3;
    end

    task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] d);
        cif.cmd_rw = rw; cif.cmd_addr = a; cif.cmd_wdata = d; cif.cmd_valid = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (cif.cmd_ready) break;
        end
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0; cif.cmd_rw = ~rw; cif.cmd_addr = ~a; cif.cmd_wdata = ~d;
    endtask

    task automatic finish_frame(input string nm);
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (cif.cmd_ready) break;
        end
        if (n == 3000) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no cmd_ready within %0d cycles, expected it", nm, n);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int dn, t0, hi, n;
        cif.cmd_valid = 1'b0; cif.cmd_rw = 1'b0; cif.cmd_addr = '0; cif.cmd_wdata = '0;
        cif3.cmd_valid = 1'b0; cif3.cmd_rw = 1'b0; cif3.cmd_addr = '0; cif3.cmd_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ncs", ncs, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_copi", copi, 0);
        chk("rst_ready", cif.cmd_ready, 1);
        chk("rst_busy", cif.busy, 0);
        chk("rst_done", cif.done, 0);
        chk("rst_rd_data", cif.rd_data, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        issue(1'b1, ADDR_EN_OUT_7_0, 8'hF0);
        @(negedge clk);
        chk("busy_in_frame", cif.busy, 1);
        finish_frame("w00");
        chk("w00_frame_const", last_frame, 16'h80F0);

        resp = 16'h00A5;
        issue(1'b0, ADDR_EN_PWM_7_0, 8'h3C);
        finish_frame("r02");
        chk("r02_frame_const", last_frame, 16'h023C);
        chk("r02_rd_const", cif.rd_data, 8'hA5);

        resp = 16'hFF5A;
        issue(1'b1, ADDR_EN_OUT_15_8, 8'h55);
        finish_frame("w01");
        chk("w01_frame_const", last_frame, 16'h8155);
        chk("w01_rd_kept", cif.rd_data, 8'hA5);

        hs_q.delete();
        cif.cmd_rw = 1'b1; cif.cmd_addr = ADDR_EN_PWM_15_8; cif.cmd_wdata = 8'h11; cif.cmd_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (i % 40 == 39) begin
                cif.cmd_wdata = cif.cmd_wdata + 8'h22;
                cif.cmd_addr = cif.cmd_addr ^ 7'h01;
            end
        end
        cif.cmd_valid = 1'b0;
        finish_frame("hold400");
        chk("hold400_count", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            chk("hold400_t1", hs_q[1] - hs_q[0], 176);
            chk("hold400_t2", hs_q[2] - hs_q[0], 352);
        end

        issue(1'b1, ADDR_PWM_DUTY, 8'h77);
        for (n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (rises == 9 && !ncs) break;
        end
        chk("rst9_reached", n < 1000, 1);
        #2 rst_n = 1'b0;
        sb.delete(); t0_ok = 1'b0; exp_rd = '0; dn = done_seen;
        #1;
        chk("rst9_ncs", ncs, 1);
        chk("rst9_sclk", sclk, 0);
        chk("rst9_copi", copi, 0);
        chk("rst9_ready", cif.cmd_ready, 1);
        chk("rst9_busy", cif.busy, 0);
        chk("rst9_rd_data", cif.rd_data, 8'h00);
        repeat (3) @(posedge clk); #1 rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("rst9_no_done", done_seen, dn);
        chk("rst9_idle", cif.cmd_ready, 1);

        @(posedge clk); #1;
        cif3.cmd_rw = 1'b1; cif3.cmd_addr = ADDR_PWM_DUTY; cif3.cmd_wdata = 8'h80; cif3.cmd_valid = 1'b1;
        @(negedge clk);
        t0 = cyc;
        chk("d3_ready", cif3.cmd_ready, 1);
        @(posedge clk); #1 cif3.cmd_valid = 1'b0; cif3.cmd_wdata = 8'h00;
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (cif3.done) break;
        end
        chk("d3_done_cyc", cyc, t0 + 100);
        chk("d3_frame", frame3, 16'h8480);
        chk("d3_rises", rises3, 16);
        hi = 0;
        for (n = 0; n < 500; n++) begin
            if (cif3.cmd_ready) break;
            if (ncs3) hi++;
            @(negedge clk);
        end
        chk("d3_ready_cyc", cyc, t0 + 110);
        chk("d3_gap_ge10", hi >= 10, 1);

        chk("no_sclk_while_ncs_high", bad_edges, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
